// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage owning the fetch PC, issuing word reads over a
// req/ack memory handshake and buffering returned words for decode.
//
// Ports:
//   CLK, Reset            clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr    read request and word-aligned address to instruction memory
//   imem_ack/imem_rdata   request completion and returned instruction word
//   inst_valid/inst_ready valid/ready handshake toward decode
//   inst/currentAddress   head instruction and its PC (0 when empty)
//   op/rs/rt/rd/func      pre-sliced MIPS fields of the head instruction
//   immediate/targe       16-bit immediate and 26-bit jump target fields
//   redirect/newAddress   taken branch/jump: flush buffer and refetch at target
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] currentAddress,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  func,
    output logic [15:0] immediate,
    output logic [25:0] targe,
    input  logic        redirect,
    input  logic [31:0] newAddress
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // DROP: the outstanding request belongs to a flushed path; its data is thrown away
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t        r_state;
    logic [31:0]   r_fpc;
    logic [31:0]   r_addr;
    logic [31:0]   r_pc   [DEPTH];
    logic [31:0]   r_word [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [31:0]   w_target;
    logic [31:0]   w_next_addr;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic          w_issue;

    always_comb begin
        w_target     = newAddress & ~32'd3;
        w_next_addr  = r_addr + 32'd4;
        w_push       = (r_state == S_REQ) && imem_ack && !redirect;
        w_pop        = inst_valid && inst_ready && !redirect;
        w_count_next = redirect ? '0 : r_count + CW'(w_push) - CW'(w_pop);
        // a new request may only be issued if its word is guaranteed a slot
        w_issue      = w_count_next < DEPTH_C;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_fpc   <= RESET_PC;
            r_addr  <= RESET_PC;
        end else if (redirect) begin
            r_fpc <= w_target;
            // an unacked request must still complete, so it is only marked for discard
            if (r_state == S_IDLE || imem_ack) begin
                r_state <= S_REQ;
                r_addr  <= w_target;
            end else begin
                r_state <= S_DROP;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_REQ;
                        r_addr  <= r_fpc;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        r_fpc <= w_next_addr;
                        if (w_issue) r_addr <= w_next_addr;
                        else r_state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        r_state <= S_REQ;
                        r_addr  <= r_fpc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
        end
    end

    // storage needs no reset: contents are only visible through a nonzero count
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_pc[r_wptr]   <= r_addr;
            r_word[r_wptr] <= imem_rdata;
        end
    end

    assign imem_req       = r_state != S_IDLE;
    assign imem_addr      = r_addr;
    assign inst_valid     = r_count != '0;
    assign inst           = inst_valid ? r_word[r_rptr] : '0;
    assign currentAddress = inst_valid ? r_pc[r_rptr] : '0;
    assign op             = inst[31:26];
    assign rs             = inst[25:21];
    assign rt             = inst[20:16];
    assign rd             = inst[15:11];
    assign func           = inst[5:0];
    assign immediate      = inst[15:0];
    assign targe          = inst[25:0];

endmodule
